// File: rtl/seq_mag_compare.sv
// Bit-serial MSB-first magnitude comparator with start/done handshake.
// Supports unsigned and two's-complement operands and exits at the first differing bit.
module seq_mag_compare #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CW-1:0]    nbits
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam logic [IW-1:0] IdxMsb    = IW'(WIDTH - 1);
    localparam logic [CW-1:0] NbitsFull = CW'(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             signed_q;
    logic [IW-1:0]    idx_q;
    logic             busy_q;
    logic             done_q;
    logic             gt_q;
    logic             eq_q;
    logic             lt_q;
    logic [CW-1:0]    nbits_q;

    logic bit_a;
    logic bit_b;
    logic differ;
    logic a_wins;

    always_comb begin
        bit_a  = a_q[idx_q];
        bit_b  = b_q[idx_q];
        differ = bit_a ^ bit_b;
        // A sign bit of 1 means the smaller value, so the MSB sense flips in signed mode.
        a_wins = (signed_q && (idx_q == IdxMsb)) ? bit_b : bit_a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            nbits_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        signed_q <= signed_mode;
                        idx_q    <= IdxMsb;
                        gt_q     <= 1'b0;
                        eq_q     <= 1'b0;
                        lt_q     <= 1'b0;
                        nbits_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StScan;
                    end
                end
                StScan: begin
                    if (differ) begin
                        gt_q    <= a_wins;
                        lt_q    <= ~a_wins;
                        nbits_q <= NbitsFull - CW'(idx_q);
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else if (idx_q == '0) begin
                        eq_q    <= 1'b1;
                        nbits_q <= NbitsFull;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign gt    = gt_q;
    assign eq    = eq_q;
    assign lt    = lt_q;
    assign nbits = nbits_q;

endmodule

// File: tb/tb_seq_mag_compare.sv
// Directed self-checking bench for seq_mag_compare at WIDTH=8.
module tb_seq_mag_compare;

    logic       clk;
    logic       rst;
    logic       start;
    logic       signed_mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic       gt;
    logic       eq;
    logic       lt;
    logic [3:0] nbits;

    int checks = 0;
    int errors = 0;

    seq_mag_compare #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .gt          (gt),
        .eq          (eq),
        .lt          (lt),
        .nbits       (nbits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one compare; optionally disturb a and pulse start right after acceptance.
    task automatic do_cmp(input string name, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic sm, input logic [7:0] a_mid, input logic poke,
                          input logic egt, input logic eeq, input logic elt, input int enb);
        int k;
        @(negedge clk);
        a = ta; b = tb_v; signed_mode = sm; start = 1'b1;
        @(negedge clk);
        a = a_mid; start = poke; signed_mode = ~sm;
        check({name, " busy"}, busy, 1);
        check({name, " cleared"}, {gt, eq, lt, nbits}, 0);
        k = 0;
        while (k < 20) begin
            @(posedge clk);
            #1;
            k++;
            start = 1'b0;
            if (done) break;
        end
        check({name, " latency"}, k, enb);
        check({name, " gt/eq/lt"}, {gt, eq, lt}, {egt, eeq, elt});
        check({name, " nbits"}, nbits, enb);
        @(posedge clk);
        #1;
        check({name, " done pulse"}, done, 0);
        check({name, " idle"}, busy, 0);
        check({name, " held"}, {gt, eq, lt, nbits}, {egt, eeq, elt, 4'(enb)});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {busy, done, gt, eq, lt, nbits}, 0);
        @(negedge clk);
        rst = 1'b0;

        do_cmp("u80_7f", 8'h80, 8'h7F, 1'b0, 8'h80, 1'b0, 1, 0, 0, 1);
        do_cmp("s80_7f", 8'h80, 8'h7F, 1'b1, 8'h80, 1'b0, 0, 0, 1, 1);
        do_cmp("eqA5",   8'hA5, 8'hA5, 1'b0, 8'hA5, 1'b0, 0, 1, 0, 8);
        do_cmp("u3c_3d", 8'h3C, 8'h3D, 1'b0, 8'h3C, 1'b0, 0, 0, 1, 8);
        do_cmp("sff_01", 8'hFF, 8'h01, 1'b1, 8'hFF, 1'b0, 0, 0, 1, 1);
        do_cmp("sf0_f8", 8'hF0, 8'hF8, 1'b1, 8'hF0, 1'b0, 0, 0, 1, 5);
        do_cmp("u12_10", 8'h12, 8'h10, 1'b0, 8'h12, 1'b0, 1, 0, 0, 7);
        // a is overwritten and start re-pulsed while scanning; captured A5 must win.
        do_cmp("mid_chg", 8'hA5, 8'hA5, 1'b1, 8'h00, 1'b1, 0, 1, 0, 8);

        // Reset during SCAN: no done, everything cleared.
        @(negedge clk);
        a = 8'hF0; b = 8'h0F; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst no done", done, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        check("rst mid-scan", {busy, done, gt, eq, lt, nbits}, 0);
        @(posedge clk);
        #1;
        check("rst stays idle", {busy, done}, 0);

        // start held high: a new compare is accepted only from IDLE.
        @(negedge clk);
        a = 8'h80; b = 8'h7F; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h00; b = 8'hFF;
        @(posedge clk);
        #1;
        check("hold first done", {done, gt, eq, lt, nbits}, {1'b1, 3'b100, 4'd1});
        @(posedge clk);
        #1;
        check("hold ignored in done", {busy, done, gt, nbits}, {3'b001, 4'd1});
        @(posedge clk);
        #1;
        check("hold accepted", {busy, done, gt, eq, lt, nbits}, {2'b10, 3'b000, 4'd0});
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("hold second done", {done, gt, eq, lt, nbits}, {1'b1, 3'b001, 4'd1});
        @(posedge clk);
        #1;
        check("hold done once", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
